// File: rtl/prim_subreg_pkg.sv
// Shared types and helpers for the shadowed subreg: access modes, phase encoding
// and mapping of the SWACCESS string parameter onto the access-mode enum.
package prim_subreg_pkg;

  typedef enum logic [2:0] {
    SwRw  = 3'd0,
    SwWo  = 3'd1,
    SwW1c = 3'd2,
    SwW1s = 3'd3,
    SwW0c = 3'd4
  } swaccess_e;

  typedef enum logic {
    PhIdle   = 1'b0,
    PhStaged = 1'b1
  } shadow_phase_e;

  // Unknown strings fall back to RW; sw_str_valid() is what rejects them.
  function automatic swaccess_e sw_str2enum(input logic [31:0] s);
    swaccess_e m;
    case (s)
      "RW":    m = SwRw;
      "WO":    m = SwWo;
      "W1C":   m = SwW1c;
      "W1S":   m = SwW1s;
      "W0C":   m = SwW0c;
      default: m = SwRw;
    endcase
    return m;
  endfunction

  function automatic logic sw_str_valid(input logic [31:0] s);
    logic ok;
    case (s)
      "RW", "WO", "W1C", "W1S", "W0C": ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/prim_subreg_shadow_arb.sv
// Next committed value for a software commit, selected by access mode.
// The shadow path uses the inverse of the same result.
module prim_subreg_shadow_arb
  import prim_subreg_pkg::*;
#(
  parameter int DW = 32
) (
  input  swaccess_e         mode,
  input  logic [DW-1:0]     committed,
  input  logic [DW-1:0]     wd,
  output logic [DW-1:0]     next
);

  // Apply the access-mode update rule to the committed value.
  always_comb begin
    next = wd;
    case (mode)
      SwRw, SwWo: next = wd;
      SwW1c:      next = committed & ~wd;
      SwW1s:      next = committed | wd;
      SwW0c:      next = committed & wd;
      default:    next = wd;
    endcase
  end

endmodule

// File: rtl/prim_subreg_shadow.sv
// Shadowed register slice: double-write commit with staged/committed/shadow storage.
// Define PRIM_SUBREG_SHADOW_STORAGE_CHK_EN to build the inverted shadow and storage check.
module prim_subreg_shadow
  import prim_subreg_pkg::*;
#(
  parameter int            DW       = 32,
  parameter logic [31:0]   SWACCESS = "RW",
  parameter logic [DW-1:0] RESVAL   = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re,
  input  logic          we,
  input  logic [DW-1:0] wd,
  input  logic          de,
  input  logic [DW-1:0] d,
  output logic          qe,
  output logic [DW-1:0] q,
  output logic [DW-1:0] qs,
  output logic          phase,
  output logic          err_update,
  output logic          err_storage
);

  localparam swaccess_e Mode = sw_str2enum(SWACCESS);

  // RO and RC fields have no software write to protect, so shadowing them is an error.
  if (!sw_str_valid(SWACCESS)) begin : g_bad_swaccess
    $error("prim_subreg_shadow: SWACCESS must be one of RW, WO, W1C, W1S, W0C");
  end

  shadow_phase_e phase_r, phase_next_s;
  logic [DW-1:0] staged_r, staged_next_s;
  logic [DW-1:0] committed_r, committed_next_s;
  logic [DW-1:0] arb_next_s;
  logic          qe_r, qe_next_s;
  logic          err_update_r, err_update_next_s;
  logic          second_we_s, match_s;

  prim_subreg_shadow_arb #(
    .DW(DW)
  ) u_arb (
    .mode      (Mode),
    .committed (committed_r),
    .wd        (wd),
    .next      (arb_next_s)
  );

  assign second_we_s = we && (phase_r == PhStaged);
  assign match_s     = (wd == staged_r);

  // Phase, stage and commit decisions; a hardware write always overrides a commit.
  always_comb begin
    phase_next_s      = phase_r;
    staged_next_s     = staged_r;
    committed_next_s  = committed_r;
    qe_next_s         = 1'b0;
    err_update_next_s = 1'b0;
    if (we) begin
      if (phase_r == PhIdle) begin
        staged_next_s = wd;
        phase_next_s  = PhStaged;
      end else begin
        phase_next_s = PhIdle;
      end
    end else if (re) begin
      phase_next_s = PhIdle;
    end else begin
      phase_next_s = phase_r;
    end

    if (de) begin
      committed_next_s = d;
    end else if (second_we_s && match_s) begin
      committed_next_s = arb_next_s;
      qe_next_s        = 1'b1;
    end else begin
      committed_next_s = committed_r;
    end
    err_update_next_s = second_we_s && !match_s;
  end

  // Protocol state and committed value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_r      <= PhIdle;
      staged_r     <= RESVAL;
      committed_r  <= RESVAL;
      qe_r         <= 1'b0;
      err_update_r <= 1'b0;
    end else begin
      phase_r      <= phase_next_s;
      staged_r     <= staged_next_s;
      committed_r  <= committed_next_s;
      qe_r         <= qe_next_s;
      err_update_r <= err_update_next_s;
    end
  end

`ifdef PRIM_SUBREG_SHADOW_STORAGE_CHK_EN
  logic [DW-1:0] shadow_r;

  // Inverted copy of the committed value, updated on exactly the same events.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_r <= ~RESVAL;
    end else begin
      shadow_r <= ~committed_next_s;
    end
  end

  assign err_storage = (committed_r != ~shadow_r);
`else
  assign err_storage = 1'b0;
`endif

  assign q          = committed_r;
  assign qs         = committed_r;
  assign qe         = qe_r;
  assign phase      = phase_r;
  assign err_update = err_update_r;

endmodule
